// File: rtl/checkpoint_ctrl_pkg.sv
// Shared definitions for the rename checkpoint controller.
//   CHECKPOINT_COUNT        number of checkpoint slots (power of 2)
//   CHECKPOINT_INDEX_WIDTH  slot index width
//   CHECKPOINT_THRESHOLD    free-slot level at or above which allocation is "plentiful"
//   checkpoint_ctrl_state_t restore sequencer states
package checkpoint_ctrl_pkg;

    localparam int CHECKPOINT_COUNT       = 8;
    localparam int CHECKPOINT_INDEX_WIDTH = $clog2(CHECKPOINT_COUNT);
    localparam int CHECKPOINT_THRESHOLD   = 3;

    typedef enum logic [1:0] {
        CKPT_IDLE          = 2'd0,
        CKPT_RESTORE_READ  = 2'd1,
        CKPT_RESTORE_APPLY = 2'd2
    } checkpoint_ctrl_state_t;

endpackage

// File: rtl/checkpoint_ctrl.sv
// In-order allocation / commit / restore sequencer for the rename checkpoint array.
//
// state              | meaning
// -------------------+-----------------------------------------------------------
// CKPT_IDLE          | normal operation, allocation allowed
// CKPT_RESTORE_READ  | reading the mispredicting branch's slot from the array
// CKPT_RESTORE_APPLY | array read data valid, map table / free list load it
//
// Ports:
//   CLK, RST                      clock, synchronous active-high reset
//   alloc_valid/ready/index       rename slot request / grant (grant is combinational)
//   alloc_plentiful, free_count   free-slot status
//   commit_valid/index            ROB frees the oldest slot
//   restore_valid/index           mispredict on a checkpointed branch
//   flush_valid                   full pipeline flush
//   array_wr_en/index             snapshot write strobe (the alloc handshake)
//   array_rd_en/index             restore read strobe
//   restore_apply_valid           read data valid for the restore consumers
//   restore_busy                  restore sequence in progress
//   protocol_error                registered pulse on an illegal commit or restore
module checkpoint_ctrl
    import checkpoint_ctrl_pkg::*;
#(
    parameter int CHECKPOINT_COUNT       = checkpoint_ctrl_pkg::CHECKPOINT_COUNT,
    parameter int CHECKPOINT_INDEX_WIDTH = $clog2(CHECKPOINT_COUNT),
    parameter int CHECKPOINT_THRESHOLD   = checkpoint_ctrl_pkg::CHECKPOINT_THRESHOLD
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              alloc_valid,
    output logic                              alloc_ready,
    output logic [CHECKPOINT_INDEX_WIDTH-1:0] alloc_index,
    output logic                              alloc_plentiful,
    output logic [CHECKPOINT_INDEX_WIDTH:0]   free_count,
    input  logic                              commit_valid,
    input  logic [CHECKPOINT_INDEX_WIDTH-1:0] commit_index,
    input  logic                              restore_valid,
    input  logic [CHECKPOINT_INDEX_WIDTH-1:0] restore_index,
    input  logic                              flush_valid,
    output logic                              array_wr_en,
    output logic [CHECKPOINT_INDEX_WIDTH-1:0] array_wr_index,
    output logic                              array_rd_en,
    output logic [CHECKPOINT_INDEX_WIDTH-1:0] array_rd_index,
    output logic                              restore_apply_valid,
    output logic                              restore_busy,
    output logic                              protocol_error
);

    localparam int CIW = CHECKPOINT_INDEX_WIDTH;
    localparam int PW  = CIW + 1;

    localparam logic [PW-1:0] COUNT_P     = PW'(CHECKPOINT_COUNT);
    localparam logic [PW-1:0] THRESHOLD_P = PW'(CHECKPOINT_THRESHOLD);

    // Pointers carry a wrap bit above the slot index so full and empty differ.
    logic [PW-1:0]          head_q;
    logic [PW-1:0]          tail_q;
    logic [CIW-1:0]         rd_index_q;
    logic                   error_q;
    checkpoint_ctrl_state_t state_q;

    logic [PW-1:0]  count;
    logic           full;
    logic           alloc_fire;
    logic           commit_ok;
    logic [CIW-1:0] restore_offset;
    logic           restore_ok;
    logic [PW-1:0]  head_d;
    logic [PW-1:0]  tail_d;

    assign count      = tail_q - head_q;
    assign full       = (count == COUNT_P);
    assign free_count = COUNT_P - count;

    assign alloc_ready     = !full && (state_q == CKPT_IDLE) && !restore_valid && !flush_valid;
    assign alloc_fire      = alloc_valid && alloc_ready;
    assign alloc_index     = tail_q[CIW-1:0];
    assign alloc_plentiful = (free_count >= THRESHOLD_P);

    assign commit_ok = commit_valid && (count != '0) && (commit_index == head_q[CIW-1:0]);

    // Age of the restored slot relative to the oldest live slot; the legality
    // check uses the pre-commit count even if a commit lands in the same cycle.
    assign restore_offset = restore_index - head_q[CIW-1:0];
    assign restore_ok     = restore_valid && ({1'b0, restore_offset} < count);

    assign head_d = head_q + PW'(commit_ok);
    // Keep the restored slot, drop everything younger.
    assign tail_d = restore_ok ? (head_q + {1'b0, restore_offset} + PW'(1))
                               : (tail_q + PW'(alloc_fire));

    always_ff @(posedge CLK) begin
        if (RST) begin
            head_q     <= '0;
            tail_q     <= '0;
            rd_index_q <= '0;
            error_q    <= 1'b0;
            state_q    <= CKPT_IDLE;
        end else if (flush_valid) begin
            head_q     <= '0;
            tail_q     <= '0;
            error_q    <= 1'b0;
            state_q    <= CKPT_IDLE;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            error_q <= (commit_valid && !commit_ok) || (restore_valid && !restore_ok);
            if (restore_ok) begin
                // A newer (older-branch) mispredict retargets from any state.
                rd_index_q <= restore_index;
                state_q    <= CKPT_RESTORE_READ;
            end else begin
                case (state_q)
                    CKPT_RESTORE_READ:  state_q <= CKPT_RESTORE_APPLY;
                    CKPT_RESTORE_APPLY: state_q <= CKPT_IDLE;
                    default:            state_q <= CKPT_IDLE;
                endcase
            end
        end
    end

    assign array_wr_en         = alloc_fire;
    assign array_wr_index      = tail_q[CIW-1:0];
    assign array_rd_en         = (state_q == CKPT_RESTORE_READ);
    assign array_rd_index      = rd_index_q;
    assign restore_apply_valid = (state_q == CKPT_RESTORE_APPLY);
    assign restore_busy        = (state_q != CKPT_IDLE);
    assign protocol_error      = error_q;

endmodule

// File: tb/tb_checkpoint_ctrl.sv
module tb_checkpoint_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       alloc_valid = 1'b0;
    logic       alloc_ready;
    logic [2:0] alloc_index;
    logic       alloc_plentiful;
    logic [3:0] free_count;
    logic       commit_valid = 1'b0;
    logic [2:0] commit_index = '0;
    logic       restore_valid = 1'b0;
    logic [2:0] restore_index = '0;
    logic       flush_valid = 1'b0;
    logic       array_wr_en;
    logic [2:0] array_wr_index;
    logic       array_rd_en;
    logic [2:0] array_rd_index;
    logic       restore_apply_valid;
    logic       restore_busy;
    logic       protocol_error;

    int n_cmp = 0;
    int n_err = 0;

    checkpoint_ctrl dut (
        .CLK                 (CLK),
        .RST                 (RST),
        .alloc_valid         (alloc_valid),
        .alloc_ready         (alloc_ready),
        .alloc_index         (alloc_index),
        .alloc_plentiful     (alloc_plentiful),
        .free_count          (free_count),
        .commit_valid        (commit_valid),
        .commit_index        (commit_index),
        .restore_valid       (restore_valid),
        .restore_index       (restore_index),
        .flush_valid         (flush_valid),
        .array_wr_en         (array_wr_en),
        .array_wr_index      (array_wr_index),
        .array_rd_en         (array_rd_en),
        .array_rd_index      (array_rd_index),
        .restore_apply_valid (restore_apply_valid),
        .restore_busy        (restore_busy),
        .protocol_error      (protocol_error)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then release single-cycle strobes.
    task automatic tick();
        @(posedge CLK);
        #1;
        alloc_valid   = 1'b0;
        commit_valid  = 1'b0;
        restore_valid = 1'b0;
        flush_valid   = 1'b0;
    endtask

    task automatic settle();
        #3;
    endtask

    initial begin
        // Reset
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        settle();
        chk("rst_free", free_count, 8);
        chk("rst_ready", alloc_ready, 1);
        chk("rst_index", alloc_index, 0);
        chk("rst_plenty", alloc_plentiful, 1);
        chk("rst_rd_en", array_rd_en, 0);
        chk("rst_apply", restore_apply_valid, 0);
        chk("rst_busy", restore_busy, 0);
        chk("rst_err", protocol_error, 0);
        chk("rst_wr_en", array_wr_en, 0);

        // Eight back-to-back allocations fill the ring
        for (int i = 0; i < 8; i++) begin
            alloc_valid = 1'b1;
            settle();
            chk("fill_wr_en", array_wr_en, 1);
            chk("fill_wr_idx", array_wr_index, i);
            chk("fill_idx", alloc_index, i);
            chk("fill_free", free_count, 8 - i);
            chk("fill_plenty", alloc_plentiful, (8 - i) >= 3);
            tick();
        end
        alloc_valid = 1'b1;
        settle();
        chk("full_ready", alloc_ready, 0);
        chk("full_wr_en", array_wr_en, 0);
        chk("full_free", free_count, 0);
        chk("full_plenty", alloc_plentiful, 0);
        tick();

        // Commit 0 with alloc at full: no grant that cycle
        commit_valid = 1'b1; commit_index = 3'd0; alloc_valid = 1'b1;
        settle();
        chk("cafull_ready", alloc_ready, 0);
        chk("cafull_wr_en", array_wr_en, 0);
        tick();
        alloc_valid = 1'b1;
        settle();
        chk("cafull_err", protocol_error, 0);
        chk("cafull_free", free_count, 1);
        chk("cafull_wr_en2", array_wr_en, 1);
        chk("cafull_wr_idx2", array_wr_index, 0);
        tick();
        settle();
        chk("cafull_free2", free_count, 0);
        chk("cafull_ready2", alloc_ready, 0);
        tick();

        // Flush empties everything
        flush_valid = 1'b1;
        tick();
        settle();
        chk("flush_free", free_count, 8);
        chk("flush_idx", alloc_index, 0);

        // Slots 0..5 live, restore 2
        for (int i = 0; i < 6; i++) begin
            alloc_valid = 1'b1;
            tick();
        end
        settle();
        chk("six_free", free_count, 2);
        restore_valid = 1'b1; restore_index = 3'd2; alloc_valid = 1'b1;
        settle();
        chk("r2_c0_ready", alloc_ready, 0);
        chk("r2_c0_wr_en", array_wr_en, 0);
        tick();
        settle();
        chk("r2_c1_rd_en", array_rd_en, 1);
        chk("r2_c1_rd_idx", array_rd_index, 2);
        chk("r2_c1_apply", restore_apply_valid, 0);
        chk("r2_c1_busy", restore_busy, 1);
        chk("r2_c1_free", free_count, 5);
        chk("r2_c1_err", protocol_error, 0);
        chk("r2_c1_ready", alloc_ready, 0);
        tick();
        settle();
        chk("r2_c2_rd_en", array_rd_en, 0);
        chk("r2_c2_apply", restore_apply_valid, 1);
        chk("r2_c2_busy", restore_busy, 1);
        tick();
        alloc_valid = 1'b1;
        settle();
        chk("r2_c3_busy", restore_busy, 0);
        chk("r2_c3_ready", alloc_ready, 1);
        chk("r2_c3_wr_idx", array_wr_index, 3);
        chk("r2_c3_wr_en", array_wr_en, 1);
        tick();
        alloc_valid = 1'b1;   // slot 4, now slots 0..4 live
        tick();

        // Restore 4, then restore 1 during APPLY restarts the sequence
        restore_valid = 1'b1; restore_index = 3'd4;
        tick();
        settle();
        chk("r4_rd_idx", array_rd_index, 4);
        chk("r4_free", free_count, 3);
        tick();
        restore_valid = 1'b1; restore_index = 3'd1;
        settle();
        chk("r1_in_apply", restore_apply_valid, 1);
        tick();
        settle();
        chk("r1_rd_en", array_rd_en, 1);
        chk("r1_rd_idx", array_rd_index, 1);
        chk("r1_apply", restore_apply_valid, 0);
        chk("r1_free", free_count, 6);
        chk("r1_tail", alloc_index, 2);
        tick();
        tick();
        settle();
        chk("r1_idle", restore_busy, 0);

        // Commit 0 (legal) then commit 3 with head=1 (illegal)
        commit_valid = 1'b1; commit_index = 3'd0;
        tick();
        settle();
        chk("c0_free", free_count, 7);
        chk("c0_err", protocol_error, 0);
        commit_valid = 1'b1; commit_index = 3'd3;
        tick();
        settle();
        chk("c3_err", protocol_error, 1);
        chk("c3_free", free_count, 7);
        tick();
        settle();
        chk("c3_err_clear", protocol_error, 0);

        // Restore of a dead slot
        restore_valid = 1'b1; restore_index = 3'd5;
        tick();
        settle();
        chk("dead_err", protocol_error, 1);
        chk("dead_rd_en", array_rd_en, 0);
        chk("dead_busy", restore_busy, 0);
        chk("dead_free", free_count, 7);
        tick();
        settle();
        chk("dead_err_clear", protocol_error, 0);

        // Wrap: head=6, slots 6,7,0,1 live
        flush_valid = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            alloc_valid = 1'b1;
            tick();
        end
        for (int i = 0; i < 6; i++) begin
            commit_valid = 1'b1; commit_index = 3'(i);
            tick();
        end
        settle();
        chk("wrap_empty", free_count, 8);
        for (int i = 0; i < 4; i++) begin
            alloc_valid = 1'b1;
            settle();
            chk("wrap_alloc_idx", array_wr_index, (6 + i) % 8);
            tick();
        end
        settle();
        chk("wrap_free", free_count, 4);
        restore_valid = 1'b1; restore_index = 3'd0;
        tick();
        settle();
        chk("wrap_r_rd_idx", array_rd_index, 0);
        chk("wrap_r_free", free_count, 5);
        chk("wrap_r_tail", alloc_index, 1);
        chk("wrap_r_err", protocol_error, 0);
        tick();
        tick();
        settle();
        chk("wrap_idle", restore_busy, 0);

        // Flush beats restore
        restore_valid = 1'b1; restore_index = 3'd7; flush_valid = 1'b1; alloc_valid = 1'b1;
        settle();
        chk("fr_ready", alloc_ready, 0);
        chk("fr_wr_en", array_wr_en, 0);
        tick();
        settle();
        chk("fr_rd_en", array_rd_en, 0);
        chk("fr_busy", restore_busy, 0);
        chk("fr_free", free_count, 8);
        chk("fr_idx", alloc_index, 0);
        chk("fr_err", protocol_error, 0);

        // Reset in the middle of a restore
        alloc_valid = 1'b1;
        tick();
        alloc_valid = 1'b1;
        tick();
        restore_valid = 1'b1; restore_index = 3'd0;
        tick();
        settle();
        chk("mr_busy_pre", restore_busy, 1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        settle();
        chk("mr_busy", restore_busy, 0);
        chk("mr_rd_en", array_rd_en, 0);
        chk("mr_free", free_count, 8);
        chk("mr_ready", alloc_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
